// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall bus width, stall patterns and FSM encodings for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  // Bit order: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb
  localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] NO_STALL  = 6'b000000;

  // Bit 0 = memory wait outstanding, bit 1 = divider wait outstanding
  localparam logic [1:0] ST_RUN          = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT     = 2'b01;
  localparam logic [1:0] ST_DIV_WAIT     = 2'b10;
  localparam logic [1:0] ST_MEM_DIV_WAIT = 2'b11;

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer with wait FSM, stall counter and watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic               if_ack,
  input  logic               ld_use,
  input  logic               div_start,
  input  logic               div_done,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               br_flush,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               timeout_err
);

  localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ERR = WCNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              pend_flush;
  logic              in_mem;
  logic              in_div;
  logic              mem_hold;
  logic              div_hold;
  logic              ex_hold;

  always_comb begin
    in_mem   = (state == ST_MEM_WAIT) || (state == ST_MEM_DIV_WAIT);
    in_div   = (state == ST_DIV_WAIT) || (state == ST_MEM_DIV_WAIT);
    mem_hold = in_mem ? !mem_ack  : (mem_req && !mem_ack);
    div_hold = in_div ? !div_done : (div_start && !div_done);
    ex_hold  = mem_hold || div_hold;
  end

  // A pure memory wait only leaves on mem_ack; otherwise the next state is just the hold pair.
  always_comb begin
    state_nxt = {div_hold, mem_hold};
    if (state == ST_MEM_WAIT) begin
      if (!mem_ack)
        state_nxt = ST_MEM_WAIT;
      else if (div_start && !div_done)
        state_nxt = ST_DIV_WAIT;
      else
        state_nxt = ST_RUN;
    end
  end

  always_comb begin
    stall = NO_STALL;
    flush = 1'b0;
    if (rst) begin
      flush = (br_flush || pend_flush) && !ex_hold;
      if (mem_hold)
        stall = STALL_MEM;
      else if (div_hold)
        stall = STALL_EX;
      else if (ld_use && !flush)
        stall = STALL_ID;
      else if (if_req && !if_ack && !flush)
        stall = STALL_IF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      pend_flush  <= 1'b0;
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // A branch seen while ex_mem holds is replayed on the first cycle it is free.
      pend_flush <= ex_hold && (pend_flush || br_flush);
      if (state == ST_RUN || state_nxt != state)
        wait_cnt <= '0;
      else if (wait_cnt != WCNT_MAX)
        wait_cnt <= wait_cnt + WCNT_W'(1);
      if (state != ST_RUN && wait_cnt == WCNT_ERR)
        timeout_err <= 1'b1;
      if (stall[0] && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
